// File: rtl/mnist_layer_sequencer_if.sv
// Datapath-side bus of the MNIST layer sequencer.
// The master drives the MAC/ROM/buffer strobes; the slave returns acc_in.
interface mnist_layer_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 15,
    parameter int SW = 10
);
    logic                 mac_clr;
    logic                 mac_en;
    logic                 src_sel;
    logic [SW-1:0]        src_addr;
    logic [AW-1:0]        w_addr;
    logic signed [DW-1:0] acc_in;
    logic                 hid_we;
    logic [5:0]           hid_addr;
    logic signed [DW-1:0] hid_wdata;

    modport master (
        output mac_clr, mac_en, src_sel, src_addr, w_addr,
        output hid_we, hid_addr, hid_wdata,
        input  acc_in
    );

    modport slave (
        input  mac_clr, mac_en, src_sel, src_addr, w_addr,
        input  hid_we, hid_addr, hid_wdata,
        output acc_in
    );
endinterface

// File: rtl/mnist_layer_sequencer.sv
// Two-layer MNIST sequencer around one shared MAC: ReLU hidden layer, argmax output.
// Optional macro PERF_CNT_EN adds cycle_count (cycles spent busy per run).
module mnist_layer_sequencer #(
    parameter int IN_N    = 784,
    parameter int H_N     = 32,
    parameter int OUT_N   = 10,
    parameter int DW      = 16,
    parameter int MAC_LAT = 2,
    parameter int AW      = 15,
    parameter int SW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    mnist_layer_sequencer_if.master bus,
    output logic        busy,
    output logic        done,
    output logic [15:0] final_prediction
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_count
`endif
);
    typedef enum logic [2:0] {
        IDLE, L1_MAC, L1_DRAIN, L1_WB, L2_MAC, L2_DRAIN, L2_CMP
    } state_t;

    state_t               state;
    logic [5:0]           neuron;
    logic [7:0]           lat_cnt;
    logic signed [DW-1:0] acc_q;
    logic signed [DW-1:0] best;
    logic [3:0]           best_idx;
    logic [SW-1:0]        k_last;
    logic                 last_k;
    logic                 last_lat;
    logic                 better;
    logic [3:0]           win_idx;

    assign k_last   = (state == L2_MAC) ? SW'(H_N - 1) : SW'(IN_N - 1);
    assign last_k   = (bus.src_addr == k_last);
    assign last_lat = (lat_cnt == 8'(MAC_LAT - 1));
    // class 0 always loads; later classes need strictly greater so ties keep lowest index
    assign better   = (neuron == 6'd0) || ($signed(acc_q) > $signed(best));
    assign win_idx  = better ? neuron[3:0] : best_idx;

    // main sequencing FSM; all datapath strobes are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            neuron           <= '0;
            lat_cnt          <= '0;
            acc_q            <= '0;
            best             <= '0;
            best_idx         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            final_prediction <= '0;
            bus.mac_clr      <= 1'b0;
            bus.mac_en       <= 1'b0;
            bus.src_sel      <= 1'b0;
            bus.src_addr     <= '0;
            bus.w_addr       <= '0;
            bus.hid_we       <= 1'b0;
            bus.hid_addr     <= '0;
            bus.hid_wdata    <= '0;
        end else begin
            bus.mac_clr <= 1'b0;
            bus.hid_we  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        done             <= 1'b0;
                        final_prediction <= '0;
                        best             <= '0;
                        best_idx         <= '0;
                        busy             <= 1'b1;
                        neuron           <= '0;
                        bus.w_addr       <= '0;
                        bus.src_sel      <= 1'b0;
                        bus.src_addr     <= '0;
                        bus.mac_en       <= 1'b1;
                        bus.mac_clr      <= 1'b1;
                        state            <= L1_MAC;
                    end
                end
                L1_MAC, L2_MAC: begin
                    bus.w_addr <= bus.w_addr + AW'(1);
                    if (last_k) begin
                        bus.mac_en <= 1'b0;
                        lat_cnt    <= '0;
                        state      <= (state == L1_MAC) ? L1_DRAIN : L2_DRAIN;
                    end else begin
                        bus.src_addr <= bus.src_addr + SW'(1);
                    end
                end
                L1_DRAIN, L2_DRAIN: begin
                    if (last_lat) begin
                        acc_q <= bus.acc_in;
                        if (state == L1_DRAIN) begin
                            bus.hid_we    <= 1'b1;
                            bus.hid_addr  <= neuron;
                            bus.hid_wdata <= ($signed(bus.acc_in) < 0) ? '0 : bus.acc_in;
                            state         <= L1_WB;
                        end else begin
                            state <= L2_CMP;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                L1_WB: begin
                    bus.src_addr <= '0;
                    bus.mac_en   <= 1'b1;
                    bus.mac_clr  <= 1'b1;
                    if (neuron == 6'(H_N - 1)) begin
                        neuron      <= '0;
                        bus.src_sel <= 1'b1;
                        state       <= L2_MAC;
                    end else begin
                        neuron <= neuron + 6'd1;
                        state  <= L1_MAC;
                    end
                end
                L2_CMP: begin
                    if (better) begin
                        best     <= acc_q;
                        best_idx <= neuron[3:0];
                    end
                    if (neuron == 6'(OUT_N - 1)) begin
                        final_prediction <= {12'b0, win_idx};
                        done             <= 1'b1;
                        busy             <= 1'b0;
                        bus.src_sel      <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        neuron       <= neuron + 6'd1;
                        bus.src_addr <= '0;
                        bus.mac_en   <= 1'b1;
                        bus.mac_clr  <= 1'b1;
                        state        <= L2_MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // counts busy cycles; stops by itself once busy drops with done
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (state == IDLE && start) begin
            cycle_count <= '0;
        end else if (busy) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif
endmodule
